// File: rtl/qpsk_seq_pkg.sv
// qpsk_seq_pkg
// Shared definitions for the QPSK phase-cycling sequencer:
//   - 2-bit phase codes in Gray order, matching the modulator's RF_phase input
//   - sequencer FSM state encoding
//   - index / count width helpers used to size the step and pulse ports
package qpsk_seq_pkg;

    localparam logic [1:0] PH_0   = 2'b00;
    localparam logic [1:0] PH_90  = 2'b01;
    localparam logic [1:0] PH_180 = 2'b11;
    localparam logic [1:0] PH_270 = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ARMED     = 2'd1,
        ST_PULSE     = 2'd2,
        ST_WAIT_SCAN = 2'd3
    } qpsk_state_e;

    // Width of an index into a table of n entries (at least 1 bit).
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Width of a count that can hold the value n itself.
    function automatic int cnt_w(input int n);
        return idx_w(n) + 1;
    endfunction

endpackage

// File: rtl/qpsk_phase_table.sv
// qpsk_phase_table
// Phase store for the sequencer: an N_STEPS x N_PULSES table of RF phase codes
// and an N_STEPS table of receiver phase codes, with one write port and one
// registered read port.
//   clk                 system clock
//   we, sel             write strobe; sel=0 selects the RF table, sel=1 the RX table
//   wr_step, wr_pulse   write address (wr_pulse unused for the RX table)
//   wr_data             phase code written
//   rd_step, rd_pulse   read address, sampled every clock
//   rf_rd, rx_rd        registered read data for the last sampled address
module qpsk_phase_table
    import qpsk_seq_pkg::*;
#(
    parameter int N_STEPS  = 8,
    parameter int N_PULSES = 4,
    localparam int SW = idx_w(N_STEPS),
    localparam int PW = idx_w(N_PULSES)
) (
    input  logic          clk,
    input  logic          we,
    input  logic          sel,
    input  logic [SW-1:0] wr_step,
    input  logic [PW-1:0] wr_pulse,
    input  logic [1:0]    wr_data,
    input  logic [SW-1:0] rd_step,
    input  logic [PW-1:0] rd_pulse,
    output logic [1:0]    rf_rd,
    output logic [1:0]    rx_rd
);

    logic [1:0] rf_mem [N_STEPS][N_PULSES];
    logic [1:0] rx_mem [N_STEPS];

    logic [1:0] rf_rd_d, rf_rd_q;
    logic [1:0] rx_rd_d, rx_rd_q;

    // Write-first bypass: a write landing on the address being read in the
    // same cycle is returned immediately, so a table write in the cycle just
    // before start is already visible to that start.
    always_comb begin
        rf_rd_d = rf_mem[rd_step][rd_pulse];
        rx_rd_d = rx_mem[rd_step];
        if (we && !sel && (wr_step == rd_step) && (wr_pulse == rd_pulse)) begin
            rf_rd_d = wr_data;
        end
        if (we && sel && (wr_step == rd_step)) begin
            rx_rd_d = wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            if (sel) begin
                rx_mem[wr_step] <= wr_data;
            end else begin
                rf_mem[wr_step][wr_pulse] <= wr_data;
            end
        end
        rf_rd_q <= rf_rd_d;
        rx_rd_q <= rx_rd_d;
    end

    assign rf_rd = rf_rd_q;
    assign rx_rd = rx_rd_q;

endmodule

// File: rtl/qpsk_phase_sequencer.sv
// qpsk_phase_sequencer
// Phase-cycling controller between the pulse-programme sequencer and the
// QPSK/DDS datapath. Steps through a programmed table of RF phases per
// (step, pulse) and one receiver phase per step, changing phases only
// between pulses.
//   clk, resetn             clock, synchronous active-low reset
//   cfg_we/sel/step/pulse/data  table write port (dropped while busy)
//   cfg_nsteps, cfg_npulses  run length, latched on start (0 behaves as 1)
//   start, abort             run control strobes
//   pulse_start, pulse_end, scan_end  pulse programme strobes
//   rf_phase, rx_phase       modulator / receiver phase codes
//   step_idx, pulse_idx      current position in the cycle
//   busy, cycle_done, seq_err  status (seq_err sticky until start/reset)
//   state_dbg                current FSM state
module qpsk_phase_sequencer
    import qpsk_seq_pkg::*;
#(
    parameter int N_PULSES = 4,
    parameter int N_STEPS  = 8,
    localparam int SW  = idx_w(N_STEPS),
    localparam int PW  = idx_w(N_PULSES),
    localparam int SCW = cnt_w(N_STEPS),
    localparam int PCW = cnt_w(N_PULSES)
) (
    input  logic           clk,
    input  logic           resetn,
    input  logic           cfg_we,
    input  logic           cfg_sel,
    input  logic [SW-1:0]  cfg_step,
    input  logic [PW-1:0]  cfg_pulse,
    input  logic [1:0]     cfg_data,
    input  logic [SCW-1:0] cfg_nsteps,
    input  logic [PCW-1:0] cfg_npulses,
    input  logic           start,
    input  logic           abort,
    input  logic           pulse_start,
    input  logic           pulse_end,
    input  logic           scan_end,
    output logic [1:0]     rf_phase,
    output logic [1:0]     rx_phase,
    output logic [SW-1:0]  step_idx,
    output logic [PW-1:0]  pulse_idx,
    output logic           busy,
    output logic           cycle_done,
    output logic           seq_err,
    output qpsk_state_e    state_dbg
);

    qpsk_state_e   state_d, state_q;
    logic [SW-1:0] step_d, step_q;
    logic [PW-1:0] pulse_d, pulse_q;
    logic [SW-1:0] last_step_d, last_step_q;
    logic [PW-1:0] last_pulse_d, last_pulse_q;
    logic [1:0]    rf_phase_d, rf_phase_q;
    logic [1:0]    rx_phase_d, rx_phase_q;
    logic          busy_d, busy_q;
    logic          cycle_done_d, cycle_done_q;
    logic          seq_err_d, seq_err_q;

    logic [SW-1:0] cfg_last_step;
    logic [PW-1:0] cfg_last_pulse;
    logic [SW-1:0] rd_step;
    logic [PW-1:0] rd_pulse;
    logic [1:0]    rf_rd;
    logic [1:0]    rx_rd;

    qpsk_phase_table #(
        .N_STEPS  (N_STEPS),
        .N_PULSES (N_PULSES)
    ) u_table (
        .clk      (clk),
        .we       (cfg_we && !busy_q),
        .sel      (cfg_sel),
        .wr_step  (cfg_step),
        .wr_pulse (cfg_pulse),
        .wr_data  (cfg_data),
        .rd_step  (rd_step),
        .rd_pulse (rd_pulse),
        .rf_rd    (rf_rd),
        .rx_rd    (rx_rd)
    );

    // Configured counts become last-index values; 0 behaves as 1 and
    // oversize values are clamped to the table size.
    always_comb begin
        cfg_last_step  = '0;
        cfg_last_pulse = '0;
        if (cfg_nsteps > SCW'(N_STEPS)) begin
            cfg_last_step = SW'(N_STEPS - 1);
        end else if (cfg_nsteps != '0) begin
            cfg_last_step = SW'(cfg_nsteps - 1'b1);
        end
        if (cfg_npulses > PCW'(N_PULSES)) begin
            cfg_last_pulse = PW'(N_PULSES - 1);
        end else if (cfg_npulses != '0) begin
            cfg_last_pulse = PW'(cfg_npulses - 1'b1);
        end
    end

    // Main FSM next-state and datapath.
    always_comb begin
        state_d      = state_q;
        step_d       = step_q;
        pulse_d      = pulse_q;
        last_step_d  = last_step_q;
        last_pulse_d = last_pulse_q;
        rf_phase_d   = rf_phase_q;
        rx_phase_d   = rx_phase_q;
        cycle_done_d = 1'b0;
        seq_err_d    = seq_err_q;

        if (abort) begin
            // Everything but the state holds its last value.
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        last_step_d  = cfg_last_step;
                        last_pulse_d = cfg_last_pulse;
                        step_d       = '0;
                        pulse_d      = '0;
                        rf_phase_d   = rf_rd;
                        rx_phase_d   = rx_rd;
                        seq_err_d    = 1'b0;
                        state_d      = ST_ARMED;
                    end
                end
                ST_ARMED: begin
                    if (pulse_start) begin
                        state_d = ST_PULSE;
                    end
                    if (pulse_end || scan_end) begin
                        seq_err_d = 1'b1;
                    end
                end
                ST_PULSE: begin
                    // A pulse_start here is an error and is dropped; a
                    // coincident pulse_end is still processed.
                    if (pulse_start) begin
                        seq_err_d = 1'b1;
                    end
                    if (pulse_end) begin
                        if (pulse_q != last_pulse_q) begin
                            pulse_d    = pulse_q + 1'b1;
                            rf_phase_d = rf_rd;
                            state_d    = ST_ARMED;
                        end else begin
                            state_d = ST_WAIT_SCAN;
                        end
                    end
                end
                ST_WAIT_SCAN: begin
                    if (pulse_start) begin
                        seq_err_d = 1'b1;
                    end
                    if (scan_end) begin
                        pulse_d    = '0;
                        rf_phase_d = rf_rd;
                        rx_phase_d = rx_rd;
                        if (step_q != last_step_q) begin
                            step_d  = step_q + 1'b1;
                            state_d = ST_ARMED;
                        end else begin
                            step_d       = '0;
                            cycle_done_d = 1'b1;
                            state_d      = ST_IDLE;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        busy_d = (state_d != ST_IDLE);
    end

    // Pre-fetch address: the table entry the *next* state will load on its
    // next event. Because it is computed from the _d values, the registered
    // read data is always valid for the current state, so a strobe can load
    // it at the very edge it is sampled.
    always_comb begin
        rd_step  = '0;
        rd_pulse = '0;
        if (state_d != ST_IDLE) begin
            if (pulse_d != last_pulse_d) begin
                rd_step  = step_d;
                rd_pulse = pulse_d + 1'b1;
            end else begin
                rd_step = (step_d == last_step_d) ? '0 : step_d + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q      <= ST_IDLE;
            step_q       <= '0;
            pulse_q      <= '0;
            last_step_q  <= '0;
            last_pulse_q <= '0;
            rf_phase_q   <= '0;
            rx_phase_q   <= '0;
            busy_q       <= 1'b0;
            cycle_done_q <= 1'b0;
            seq_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            step_q       <= step_d;
            pulse_q      <= pulse_d;
            last_step_q  <= last_step_d;
            last_pulse_q <= last_pulse_d;
            rf_phase_q   <= rf_phase_d;
            rx_phase_q   <= rx_phase_d;
            busy_q       <= busy_d;
            cycle_done_q <= cycle_done_d;
            seq_err_q    <= seq_err_d;
        end
    end

    assign rf_phase   = rf_phase_q;
    assign rx_phase   = rx_phase_q;
    assign step_idx   = step_q;
    assign pulse_idx  = pulse_q;
    assign busy       = busy_q;
    assign cycle_done = cycle_done_q;
    assign seq_err    = seq_err_q;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_qpsk_phase_sequencer.sv
// tb_qpsk_phase_sequencer
// Directed bench for qpsk_phase_sequencer. Every driver tick states the full
// expected output snapshot for the cycle after its edge; whenever that
// snapshot differs from the previous one it is queued with its cycle stamp.
// A monitor watches the DUT outputs on the falling edge and, whenever they
// change, pops the next expected entry and compares value and cycle.
module tb_qpsk_phase_sequencer;
    import qpsk_seq_pkg::*;

    localparam int N_PULSES = 4;
    localparam int N_STEPS  = 8;
    localparam int SNAP_W   = 12;
    localparam int W        = 32 + SNAP_W;

    logic        clk;
    logic        resetn;
    logic        cfg_we;
    logic        cfg_sel;
    logic [2:0]  cfg_step;
    logic [1:0]  cfg_pulse;
    logic [1:0]  cfg_data;
    logic [3:0]  cfg_nsteps;
    logic [2:0]  cfg_npulses;
    logic        start;
    logic        abort;
    logic        pulse_start;
    logic        pulse_end;
    logic        scan_end;
    logic [1:0]  rf_phase;
    logic [1:0]  rx_phase;
    logic [2:0]  step_idx;
    logic [1:0]  pulse_idx;
    logic        busy;
    logic        cycle_done;
    logic        seq_err;
    qpsk_state_e state_dbg;

    qpsk_phase_sequencer #(
        .N_PULSES (N_PULSES),
        .N_STEPS  (N_STEPS)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .cfg_we      (cfg_we),
        .cfg_sel     (cfg_sel),
        .cfg_step    (cfg_step),
        .cfg_pulse   (cfg_pulse),
        .cfg_data    (cfg_data),
        .cfg_nsteps  (cfg_nsteps),
        .cfg_npulses (cfg_npulses),
        .start       (start),
        .abort       (abort),
        .pulse_start (pulse_start),
        .pulse_end   (pulse_end),
        .scan_end    (scan_end),
        .rf_phase    (rf_phase),
        .rx_phase    (rx_phase),
        .step_idx    (step_idx),
        .pulse_idx   (pulse_idx),
        .busy        (busy),
        .cycle_done  (cycle_done),
        .seq_err     (seq_err),
        .state_dbg   (state_dbg)
    );

    // ---------------- clock / cycle counter ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] cyc = '0;
    always @(posedge clk) cyc <= cyc + 32'd1;

    // ---------------- scoreboard state ----------------
    int checks   = 0;
    int failures = 0;
    logic [W-1:0]      exp_q[$];
    logic [SNAP_W-1:0] last_snap = '0;
    logic [SNAP_W-1:0] prev_snap = '0;
    logic              mon_en    = 1'b0;

    // Expected outputs for the cycle following the next edge.
    logic [1:0] x_rf    = '0;
    logic [1:0] x_rx    = '0;
    logic [2:0] x_step  = '0;
    logic [1:0] x_pulse = '0;
    logic       x_busy  = 1'b0;
    logic       x_err   = 1'b0;

    // Stimulus tables.
    logic [1:0] gray4 [4]    = '{PH_0, PH_90, PH_180, PH_270};
    logic [1:0] mp_rf [2][3] = '{'{PH_0, PH_90, PH_0}, '{PH_180, PH_270, PH_180}};
    logic [1:0] e_rf  [4]    = '{PH_180, PH_180, PH_270, PH_0};
    logic [1:0] e_rx  [4]    = '{PH_90, PH_180, PH_270, PH_270};

    function automatic logic [SNAP_W-1:0] dut_snap();
        return {rf_phase, rx_phase, step_idx, pulse_idx, busy, cycle_done, seq_err};
    endfunction

    // ---------------- monitor ----------------
    always @(negedge clk) begin : monitor
        logic [SNAP_W-1:0] cur;
        logic [W-1:0]      e;
        if (mon_en) begin
            cur = dut_snap();
            if (cur != prev_snap) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_change cyc=%0d got snap=%h, required no change from %h",
                             cyc, cur, prev_snap);
                end else begin
                    e = exp_q.pop_front();
                    if (e != {cyc, cur}) begin
                        failures++;
                        $display("FAIL output_change got cyc=%0d snap=%h, required cyc=%0d snap=%h",
                                 cyc, cur, e[W-1:SNAP_W], e[SNAP_W-1:0]);
                    end
                end
                prev_snap = cur;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input logic cd);
        logic [W-1:0] e;
        e = {cyc + 32'd1, x_rf, x_rx, x_step, x_pulse, x_busy, cd, x_err};
        if (e[SNAP_W-1:0] != last_snap) begin
            exp_q.push_back(e);
            last_snap = e[SNAP_W-1:0];
        end
        @(posedge clk);
        #1;
        start       = 1'b0;
        abort       = 1'b0;
        pulse_start = 1'b0;
        pulse_end   = 1'b0;
        scan_end    = 1'b0;
        cfg_we      = 1'b0;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0);
    endtask

    task automatic wr(input logic sel, input logic [2:0] st, input logic [1:0] pu,
                      input logic [1:0] d);
        cfg_we    = 1'b1;
        cfg_sel   = sel;
        cfg_step  = st;
        cfg_pulse = pu;
        cfg_data  = d;
        tick(1'b0);
    endtask

    task automatic do_start(input logic [3:0] ns, input logic [2:0] np,
                            input logic [1:0] rf0, input logic [1:0] rx0);
        cfg_nsteps  = ns;
        cfg_npulses = np;
        start       = 1'b1;
        x_rf        = rf0;
        x_rx        = rx0;
        x_step      = '0;
        x_pulse     = '0;
        x_busy      = 1'b1;
        x_err       = 1'b0;
        tick(1'b0);
    endtask

    task automatic do_ps();
        pulse_start = 1'b1;
        tick(1'b0);
    endtask

    task automatic do_pe();
        pulse_end = 1'b1;
        tick(1'b0);
    endtask

    task automatic do_both();
        pulse_start = 1'b1;
        pulse_end   = 1'b1;
        tick(1'b0);
    endtask

    task automatic do_se(input logic cd);
        scan_end = 1'b1;
        tick(cd);
    endtask

    task automatic do_abort();
        abort = 1'b1;
        tick(1'b0);
    endtask

    task automatic randomize_inputs();
        cfg_we      = 1'($urandom_range(0, 1));
        cfg_sel     = 1'($urandom_range(0, 1));
        cfg_step    = 3'($urandom_range(0, 7));
        cfg_pulse   = 2'($urandom_range(0, 3));
        cfg_data    = 2'($urandom_range(0, 3));
        cfg_nsteps  = 4'($urandom_range(0, 15));
        cfg_npulses = 3'($urandom_range(0, 7));
        start       = 1'($urandom_range(0, 1));
        abort       = 1'($urandom_range(0, 1));
        pulse_start = 1'($urandom_range(0, 1));
        pulse_end   = 1'($urandom_range(0, 1));
        scan_end    = 1'($urandom_range(0, 1));
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog timeout at cyc=%0d, required end of test", cyc);
        $fatal(1, "bench timeout");
    end

    // ---------------- main sequence ----------------
    initial begin
        resetn = 1'b0;
        randomize_inputs();
        repeat (3) begin
            @(posedge clk);
            #1;
            randomize_inputs();
        end
        @(negedge clk);
        checks++;
        if (dut_snap() != '0 || state_dbg != ST_IDLE) begin
            failures++;
            $display("FAIL reset got snap=%h state=%0d, required snap=0 state=0",
                     dut_snap(), state_dbg);
        end

        resetn      = 1'b1;
        cfg_we      = 1'b0;
        cfg_sel     = 1'b0;
        cfg_step    = '0;
        cfg_pulse   = '0;
        cfg_data    = '0;
        cfg_nsteps  = '0;
        cfg_npulses = '0;
        start       = 1'b0;
        abort       = 1'b0;
        pulse_start = 1'b0;
        pulse_end   = 1'b0;
        scan_end    = 1'b0;
        prev_snap   = '0;
        mon_en      = 1'b1;
        idle(2);

        // CYCLOPS: 4 steps x 1 pulse, RF and RX both walk 0/90/180/270.
        for (int s = 0; s < 4; s++) begin
            wr(1'b0, 3'(s), 2'd0, gray4[s]);
            wr(1'b1, 3'(s), 2'd0, gray4[s]);
        end
        do_start(4'd4, 3'd1, PH_0, PH_0);
        for (int s = 0; s < 4; s++) begin
            do_ps();
            do_pe();
            if (s < 3) begin
                x_step = 3'(s + 1);
                x_rf   = gray4[s + 1];
                x_rx   = gray4[s + 1];
                do_se(1'b0);
            end else begin
                x_step = '0;
                x_rf   = PH_0;
                x_rx   = PH_0;
                x_busy = 1'b0;
                do_se(1'b1);
            end
        end
        idle(1);

        // Multi-pulse: 2 steps x 3 pulses, idle cycles inside each pulse.
        for (int s = 0; s < 2; s++) begin
            for (int p = 0; p < 3; p++) wr(1'b0, 3'(s), 2'(p), mp_rf[s][p]);
        end
        wr(1'b1, 3'd0, 2'd0, PH_270);
        wr(1'b1, 3'd1, 2'd0, PH_90);
        do_start(4'd2, 3'd3, PH_0, PH_270);
        for (int s = 0; s < 2; s++) begin
            for (int p = 0; p < 3; p++) begin
                do_ps();
                idle(1);
                if (p < 2) begin
                    x_pulse = 2'(p + 1);
                    x_rf    = mp_rf[s][p + 1];
                end
                do_pe();
                idle(1);
            end
            x_pulse = '0;
            if (s == 0) begin
                x_step = 3'd1;
                x_rf   = PH_180;
                x_rx   = PH_90;
                do_se(1'b0);
            end else begin
                x_step = '0;
                x_rf   = PH_0;
                x_rx   = PH_270;
                x_busy = 1'b0;
                do_se(1'b1);
            end
        end
        idle(1);

        // Protocol errors: scan_end while armed, then coincident start/end.
        do_start(4'd2, 3'd3, PH_0, PH_270);
        x_err = 1'b1;
        do_se(1'b0);
        do_ps();
        x_pulse = 2'd1;
        x_rf    = PH_90;
        do_both();
        do_pe();                 // armed again: error only, no advance
        do_ps();
        x_pulse = 2'd2;
        x_rf    = PH_0;
        do_pe();
        x_busy = 1'b0;
        do_abort();
        idle(1);

        // Abort mid-pulse at step 2; fresh error from coincident strobes.
        do_start(4'd4, 3'd1, PH_0, PH_270);
        do_ps();
        x_err = 1'b1;
        do_both();
        x_step = 3'd1;
        x_rf   = PH_180;
        x_rx   = PH_90;
        do_se(1'b0);
        do_ps();
        do_pe();
        x_step = 3'd2;
        x_rf   = PH_180;
        x_rx   = PH_180;
        do_se(1'b0);
        do_ps();
        x_busy = 1'b0;
        do_abort();
        idle(2);

        // Restart, then try to overwrite RF[0][0] during the run.
        do_start(4'd4, 3'd1, PH_0, PH_270);
        wr(1'b0, 3'd0, 2'd0, PH_180);
        for (int s = 0; s < 4; s++) begin
            do_ps();
            do_pe();
            x_step = (s < 3) ? 3'(s + 1) : 3'd0;
            x_rf   = e_rf[s];
            x_rx   = e_rx[s];
            if (s == 3) x_busy = 1'b0;
            do_se((s == 3) ? 1'b1 : 1'b0);
        end
        idle(1);
        do_start(4'd4, 3'd1, PH_0, PH_270);
        x_busy = 1'b0;
        do_abort();
        idle(1);

        // Zero config behaves as 1 step x 1 pulse.
        wr(1'b0, 3'd0, 2'd0, PH_90);
        do_start(4'd0, 3'd0, PH_90, PH_270);
        do_ps();
        do_pe();
        x_busy = 1'b0;
        do_se(1'b1);
        idle(2);

        @(posedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL pending_expected got %0d unmatched entries, required 0",
                     exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/qpsk_phase_sequencer.md
# qpsk_phase_sequencer

Phase-cycling controller for the transmit QPSK modulator and receiver phase path. Holds a programmable table of RF phases per (cycle step, pulse) plus one receiver phase per step. It drives the modulator's 2-bit `RF_phase` and the receiver phase select, changing them only between pulses. It sits between the pulse-programme sequencer, which supplies pulse and scan strobes, and the QPSK/DDS datapath.

## Interface
- N_PULSES, 4: max pulses per scan (power of 2, ≤16)
- N_STEPS, 8: max phase-cycle steps (power of 2, ≤16)
- clk  in  1  system clock; all logic on rising edge
- resetn  in  1  synchronous, active-low reset
- cfg_we  in  1  table write strobe; ignored while busy=1
- cfg_sel  in  1  0 = RF table, 1 = RX table
- cfg_step  in  log2(N_STEPS)  step index of write
- cfg_pulse  in  log2(N_PULSES)  pulse index of write; ignored for RX table
- cfg_data  in  2  phase code written
- cfg_nsteps  in  log2(N_STEPS)+1  steps used; 0 treated as 1; sampled at start
- cfg_npulses  in  log2(N_PULSES)+1  pulses per scan; 0 treated as 1; sampled at start
- start  in  1  1-cycle strobe; accepted only in IDLE
- abort  in  1  1-cycle strobe; highest priority after reset
- pulse_start  in  1  strobe: pulse begins
- pulse_end  in  1  strobe: pulse ends
- scan_end  in  1  strobe: acquisition of current scan complete
- rf_phase  out  2  to modulator RF_phase
- rx_phase  out  2  receiver phase select
- step_idx  out  log2(N_STEPS)  current step
- pulse_idx  out  log2(N_PULSES)  current pulse
- busy  out  1  high outside IDLE
- cycle_done  out  1  1-cycle strobe on last step's scan_end
- seq_err  out  1  sticky protocol-error flag; cleared by start or reset

## Operation
- Phase codes: 00 = 0°, 01 = 90°, 11 = 180°, 10 = 270° (Gray order, matches modulator).
- States: IDLE, ARMED (waiting for pulse), PULSE, WAIT_SCAN.
- IDLE: on start, latch cfg_nsteps/cfg_npulses, step=0, pulse=0, rf_phase=RF[0][0], rx_phase=RX[0], clear seq_err -> ARMED.
- ARMED: pulse_start -> PULSE. scan_end or pulse_end sets seq_err and is otherwise ignored.
- PULSE: rf_phase frozen. On pulse_end, if pulse < npulses-1: pulse++, rf_phase=RF[step][pulse+1] -> ARMED. Otherwise -> WAIT_SCAN. pulse_start sets seq_err.
- WAIT_SCAN: on scan_end, pulse=0. If step < nsteps-1: step++, load RF[step+1][0] and RX[step+1] -> ARMED. Otherwise step wraps to 0, loads RF[0][0] and RX[0], cycle_done=1 for one cycle -> IDLE. pulse_start sets seq_err.
- Simultaneous pulse_start and pulse_end in PULSE: process pulse_end; pulse_start sets seq_err and is dropped.
- abort in any state -> IDLE next cycle. Counters and outputs hold their last values. Table contents are kept.
- Table writes while busy=1 are dropped silently. Writes in IDLE take effect at the next start.

## Timing
- Reset (resetn=0 at edge): state IDLE; rf_phase, rx_phase, step_idx, pulse_idx = 0; busy, cycle_done, seq_err = 0. Table contents undefined.
- All outputs are registered. A strobe sampled at edge k updates outputs visible after edge k.
- The rf_phase update follows pulse_end by 1 cycle. The pulse programme must keep a gap of at least 2 cycles before the next pulse_start.
- busy rises 1 cycle after start and falls in the same cycle cycle_done is asserted.
- Table read is synchronous and pre-fetched, so there are no extra latency cycles.

## Structure
- Package `qpsk_seq_pkg`: phase code constants (PH_0, PH_90, PH_180, PH_270), state enum, index width functions.
- Sub-module `qpsk_phase_table`: N_STEPS×N_PULSES×2-bit RF store plus N_STEPS×2-bit RX store. Has a write port and a registered read port addressed by next (step, pulse).
- Top holds the FSM, counters and error logic. Target size is about 200 lines.

## Test plan
- Reset: hold resetn=0 for 3 cycles with random inputs -> all outputs 0, busy=0.
- CYCLOPS: nsteps=4, npulses=1; RF={00,01,11,10}, RX={00,01,11,10}; 4 × (pulse_start, pulse_end, scan_end) -> rf_phase/rx_phase step 0°,90°,180°,270°; cycle_done once after 4th scan_end; busy=0.
- Multi-pulse: nsteps=2, npulses=3; RF[0]={00,01,00}, RF[1]={11,10,11} -> rf_phase changes exactly 1 cycle after each pulse_end; never changes in PULSE.
- Protocol errors: scan_end in ARMED, then pulse_start and pulse_end together in PULSE -> seq_err=1 and stays set; FSM advances only on pulse_end.
- Abort mid-PULSE at step 2 -> IDLE next cycle, busy=0; a new start reloads step 0 and clears seq_err.
- Write while busy: overwrite RF[0][0] during a run -> no effect on the current run; the value is still the old one after restart.
- Zero config: nsteps=0, npulses=0 -> behaves as 1/1; cycle_done after first scan_end.
